rf_param: RTL and testbench

- Parametrised successor to the calculator's 4x3-bit register file.
- Configurable data width and depth; two read ports with a registered 1-cycle read latency; async reset.
- Synchronous bulk clear and a per-entry written/valid scoreboard, so the datapath control FSM can detect reads of never-written operands.
- Sits between the calculator control FSM and the ALU operand muxes.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_param_if.sv | 36 +++
 rtl/rf_read_port.sv | 67 ++++++
 rtl/rf_param.sv | 83 ++++++++
 tb/tb_rf_param.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised operand register file.
// Holds the default geometry, word/address typedefs for the default build,
// and the address range helper used by both write and read paths.
// Optional feature macro used by rf_param / rf_read_port: RF_BYPASS_EN.
package rf_pkg;

  localparam int RF_DW = 3;
  localparam int RF_AW = 2;

  typedef logic [RF_DW-1:0] rf_data_t;
  typedef logic [RF_AW-1:0] rf_addr_t;

  // Addresses are zero-extended to 32 bits by the caller so one helper
  // serves any address width.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/rf_param_if.sv
// Bus between the calculator control FSM (master) and the register file
// (slave).
//   master drives: clr, rea, raa, reb, rab, we, wa, din
//   slave drives : douta, doutb, vlda, vldb, wr_err (all registered)
interface rf_param_if
  import rf_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
);

  logic          clr;
  logic          rea;
  logic [AW-1:0] raa;
  logic          reb;
  logic [AW-1:0] rab;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] din;
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;
  logic          vlda;
  logic          vldb;
  logic          wr_err;

  modport master (
    output clr, rea, raa, reb, rab, we, wa, din,
    input  douta, doutb, vlda, vldb, wr_err
  );

  modport slave (
    input  clr, rea, raa, reb, rab, we, wa, din,
    output douta, doutb, vlda, vldb, wr_err
  );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port of rf_param.
// Ports:
//   clk, rst        clock, async active-high reset
//   re, ra          read enable / address
//   mem, valid      storage and written-flags from the parent
//   wr_fire, wa,    (RF_BYPASS_EN only) in-range write this cycle, its
//   din, clr        address/data, and the clear strobe
//   dout, vld       registered read data and valid flag
// Disabled or out-of-range reads register zero data with vld low.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 1 << AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      re,
  input  logic [AW-1:0]             ra,
  input  logic [DEPTH-1:0][DW-1:0]  mem,
  input  logic [DEPTH-1:0]          valid,
`ifdef RF_BYPASS_EN
  input  logic                      wr_fire,
  input  logic [AW-1:0]             wa,
  input  logic [DW-1:0]             din,
  input  logic                      clr,
`endif
  output logic [DW-1:0]             dout,
  output logic                      vld
);

  logic [DW-1:0] nxt_dout;
  logic          nxt_vld;

  always_comb begin
    nxt_dout = '0;
    nxt_vld  = 1'b0;
    if (re && in_range(32'(ra), DEPTH)) begin
`ifdef RF_BYPASS_EN
      // Write-first: forward the incoming word; during a clear every other
      // entry is about to become zero/invalid, so report it that way.
      if (wr_fire && (ra == wa)) begin
        nxt_dout = din;
        nxt_vld  = 1'b1;
      end else if (!clr) begin
        nxt_dout = mem[ra];
        nxt_vld  = valid[ra];
      end
`else
      nxt_dout = mem[ra];
      nxt_vld  = valid[ra];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      dout <= nxt_dout;
      vld  <= nxt_vld;
    end
  end

endmodule

// File: rtl/rf_param.sv
// Parametrised operand register file with two registered read ports,
// synchronous bulk clear and a per-entry written/valid scoreboard.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rf_param_if.slave (clr, reads A/B, write, registered outputs)
// DEPTH must lie in [2, 2**AW]; addresses at or above DEPTH are ignored
// for storage and flagged on wr_err when written.
// Optional macro RF_BYPASS_EN: read ports forward a same-cycle write.
module rf_param
  import rf_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 1 << AW
) (
  input logic        clk,
  input logic        rst,
  rf_param_if.slave  bus
);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [DEPTH-1:0]         valid;
  logic                     wr_fire;
  logic                     wr_err_q;

  assign wr_fire    = bus.we && in_range(32'(bus.wa), DEPTH);
  assign bus.wr_err = wr_err_q;

  // Clear first, then the write, so a write in a clear cycle survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem      <= '0;
      valid    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (bus.clr) begin
        mem   <= '0;
        valid <= '0;
      end
      if (wr_fire) begin
        mem[bus.wa]   <= bus.din;
        valid[bus.wa] <= 1'b1;
      end
      wr_err_q <= bus.we && !wr_fire;
    end
  end

  rf_read_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .re      (bus.rea),
    .ra      (bus.raa),
    .mem     (mem),
    .valid   (valid),
`ifdef RF_BYPASS_EN
    .wr_fire (wr_fire),
    .wa      (bus.wa),
    .din     (bus.din),
    .clr     (bus.clr),
`endif
    .dout    (bus.douta),
    .vld     (bus.vlda)
  );

  rf_read_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .re      (bus.reb),
    .ra      (bus.rab),
    .mem     (mem),
    .valid   (valid),
`ifdef RF_BYPASS_EN
    .wr_fire (wr_fire),
    .wa      (bus.wa),
    .din     (bus.din),
    .clr     (bus.clr),
`endif
    .dout    (bus.doutb),
    .vld     (bus.vldb)
  );

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: a DEPTH=4 instance for the main behaviour and
// a DEPTH=3 instance for out-of-range accesses. Expected outputs are queued
// one cycle ahead and compared by an independent monitor on the falling edge.
module tb_rf_param;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string      name;
    bit         d3;
    logic [2:0] da;
    logic       va;
    logic [2:0] db;
    logic       vb;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  rf_param_if #(.DW(3), .AW(2)) b4 ();
  rf_param_if #(.DW(3), .AW(2)) b3 ();

  rf_param #(.DW(3), .AW(2), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  rf_param #(.DW(3), .AW(2), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input bit d3,
                              input logic [2:0] da, input logic va,
                              input logic [2:0] db, input logic vb,
                              input logic err);
    exp_t e;
    e.name = name; e.d3 = d3;
    e.da = da; e.va = va; e.db = db; e.vb = vb; e.err = err;
    return e;
  endfunction

  // Monitor: one expectation per rising edge, checked half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.d3) begin
        chk({e.name, ".douta"},  b3.douta,          e.da);
        chk({e.name, ".vlda"},   {2'b0, b3.vlda},   {2'b0, e.va});
        chk({e.name, ".doutb"},  b3.doutb,          e.db);
        chk({e.name, ".vldb"},   {2'b0, b3.vldb},   {2'b0, e.vb});
        chk({e.name, ".wr_err"}, {2'b0, b3.wr_err}, {2'b0, e.err});
      end else begin
        chk({e.name, ".douta"},  b4.douta,          e.da);
        chk({e.name, ".vlda"},   {2'b0, b4.vlda},   {2'b0, e.va});
        chk({e.name, ".doutb"},  b4.doutb,          e.db);
        chk({e.name, ".vldb"},   {2'b0, b4.vldb},   {2'b0, e.vb});
        chk({e.name, ".wr_err"}, {2'b0, b4.wr_err}, {2'b0, e.err});
      end
    end
  end

  task automatic idle();
    b4.clr = 0; b4.rea = 0; b4.raa = 0; b4.reb = 0; b4.rab = 0;
    b4.we = 0; b4.wa = 0; b4.din = 0;
    b3.clr = 0; b3.rea = 0; b3.raa = 0; b3.reb = 0; b3.rab = 0;
    b3.we = 0; b3.wa = 0; b3.din = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input exp_t e);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic wr4(input logic [1:0] a, input logic [2:0] d);
    idle(); b4.we = 1; b4.wa = a; b4.din = d;
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state.douta", b4.douta, 3'b000);
    chk("rst_state.vlda", {2'b0, b4.vlda}, 3'b000);
    chk("rst_state.wr_err", {2'b0, b4.wr_err}, 3'b000);
    rst = 1'b0;

    // Latency: write entry 1, read it, then disable the read.
    wr4(2'd1, 3'b110);
    idle(); b4.rea = 1; b4.raa = 2'd1;
    cyc(mk("lat_read", 0, 3'b110, 1, 3'b000, 0, 0));
    idle();
    cyc(mk("lat_disabled", 0, 3'b000, 0, 3'b000, 0, 0));

    // Both ports on the same address.
    wr4(2'd3, 3'b011);
    idle(); b4.rea = 1; b4.raa = 2'd3; b4.reb = 1; b4.rab = 2'd3;
    cyc(mk("dual_same", 0, 3'b011, 1, 3'b011, 1, 0));

    // Never-written entry reads zero / invalid; port B independent.
    idle(); b4.rea = 1; b4.raa = 2'd2; b4.reb = 1; b4.rab = 2'd1;
    cyc(mk("unwritten", 0, 3'b000, 0, 3'b110, 1, 0));

    // Same-cycle write/read of entry 0.
    wr4(2'd0, 3'b001);
    idle(); b4.we = 1; b4.wa = 2'd0; b4.din = 3'b111;
    b4.rea = 1; b4.raa = 2'd0; b4.reb = 1; b4.rab = 2'd1;
    cyc(mk("rw_same", 0, BYP ? 3'b111 : 3'b001, 1, 3'b110, 1, 0));
    idle(); b4.rea = 1; b4.raa = 2'd0;
    cyc(mk("rw_after", 0, 3'b111, 1, 3'b000, 0, 0));

    // Clear together with a write to entry 2.
    wr4(2'd2, 3'b010);
    idle(); b4.clr = 1; b4.we = 1; b4.wa = 2'd2; b4.din = 3'b100;
    b4.rea = 1; b4.raa = 2'd2; b4.reb = 1; b4.rab = 2'd1;
    cyc(mk("clr_cycle", 0, BYP ? 3'b100 : 3'b010, 1,
           BYP ? 3'b000 : 3'b110, BYP ? 1'b0 : 1'b1, 0));
    idle(); b4.rea = 1; b4.raa = 2'd0; b4.reb = 1; b4.rab = 2'd1;
    cyc(mk("clr_e0_e1", 0, 3'b000, 0, 3'b000, 0, 0));
    idle(); b4.rea = 1; b4.raa = 2'd2; b4.reb = 1; b4.rab = 2'd3;
    cyc(mk("clr_e2_e3", 0, 3'b100, 1, 3'b000, 0, 0));

    // Asynchronous reset while outputs are non-zero.
    wr4(2'd2, 3'b101);
    idle(); b4.rea = 1; b4.raa = 2'd2; b4.reb = 1; b4.rab = 2'd2;
    cyc(mk("pre_rst", 0, 3'b101, 1, 3'b101, 1, 0));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst.douta", b4.douta, 3'b000);
    chk("async_rst.vlda", {2'b0, b4.vlda}, 3'b000);
    chk("async_rst.doutb", b4.doutb, 3'b000);
    chk("async_rst.vldb", {2'b0, b4.vldb}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(); b4.rea = 1; b4.raa = 2'd2;
    cyc(mk("post_rst", 0, 3'b000, 0, 3'b000, 0, 0));

    // Out-of-range accesses on the DEPTH=3 instance.
    idle(); b3.we = 1; b3.wa = 2'd2; b3.din = 3'b101;
    tick();
    idle(); b3.we = 1; b3.wa = 2'd3; b3.din = 3'b111;
    b3.rea = 1; b3.raa = 2'd2;
    cyc(mk("oor_write", 1, 3'b101, 1, 3'b000, 0, 1));
    idle(); b3.rea = 1; b3.raa = 2'd3; b3.reb = 1; b3.rab = 2'd2;
    cyc(mk("oor_read", 1, 3'b000, 0, 3'b101, 1, 0));
    idle(); b3.we = 1; b3.wa = 2'd0; b3.din = 3'b011;
    cyc(mk("inr_write", 1, 3'b000, 0, 3'b000, 0, 0));
    idle(); b3.rea = 1; b3.raa = 2'd0; b3.reb = 1; b3.rab = 2'd1;
    cyc(mk("inr_read", 1, 3'b011, 1, 3'b000, 0, 0));

    idle();
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
